// File: rtl/adc_lvds_tx_emulator_if.sv
// Parallel-side handshake plus serial lane/frame outputs of adc_lvds_tx_emulator.
// The master drives controls and samples. The slave, which is the emulator, drives the lanes.
interface adc_lvds_tx_emulator_if #(
    parameter int D = 16
);
    logic         enable;
    logic [1:0]   mode;
    logic [D-1:0] pattern;
    logic [D-1:0] sample_in;
    logic         sample_valid;
    logic         sample_ready;
    logic [1:0]   lane_rise;
    logic [1:0]   lane_fall;
    logic         frame_rise;
    logic         frame_fall;
    logic         word_start;
    logic         in_sync;
    logic         underflow;

    modport master (
        output enable, mode, pattern, sample_in, sample_valid,
        input  sample_ready, lane_rise, lane_fall, frame_rise, frame_fall,
               word_start, in_sync, underflow
    );

    modport slave (
        input  enable, mode, pattern, sample_in, sample_valid,
        output sample_ready, lane_rise, lane_fall, frame_rise, frame_fall,
               word_start, in_sync, underflow
    );
endinterface

// File: rtl/adc_lvds_tx_emulator.sv
// Two-lane DDR LVDS ADC output emulator: emits SYNC training words, then data, pattern, ramp or PRBS words.
// Define ADC_TX_PRBS_EN to build the PRBS9 source for mode 3. Without it, mode 3 repeats the fixed pattern.
module adc_lvds_tx_emulator #(
    parameter int D          = 16,
    parameter int S          = 8,
    parameter int SYNC_WORDS = 16
) (
    input  logic                     i_ref_clk,
    input  logic                     i_ref_rst_n,
    adc_lvds_tx_emulator_if.slave    bus
);
    localparam int KW = (S > 2) ? $clog2(S / 2) : 1;
    localparam int CW = (SYNC_WORDS > 1) ? $clog2(SYNC_WORDS) : 1;
    localparam logic [KW-1:0] K_LAST   = KW'(S / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(SYNC_WORDS - 1);
    localparam logic [D-1:0]  TRAIN    = {S{2'b10}};
    localparam logic [S-1:0]  FRAME    = {{(S / 2){1'b1}}, {(S / 2){1'b0}}};

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t        r_state, w_state_nx;
    logic [KW-1:0] r_k, w_k_nx;
    logic [CW-1:0] r_cnt, w_cnt_nx;
    logic [D-1:0]  r_word, w_word_nx;
    logic [S-1:0]  r_frame, w_frame_nx;
    logic [D-1:0]  r_ramp, w_ramp_nx, w_ramp_cur;
    logic          r_stop, w_stop_nx;
    logic          r_underflow, w_uflow_nx;
    logic          w_ready_nx;
    logic [1:0]    r_lane_rise, r_lane_fall;
    logic          r_frame_rise, r_frame_fall, r_word_start, r_in_sync, r_sample_ready;

    assign w_ramp_cur = (r_state == SYNC) ? '0 : r_ramp;

`ifdef ADC_TX_PRBS_EN
    logic [8:0]   r_prbs, w_prbs_nx, w_prbs_cur, w_prbs_adv;
    logic [D-1:0] w_prbs_word;

    assign w_prbs_cur = (r_state == SYNC) ? 9'h1FF : r_prbs;

    // Step x^9+x^5+1 D times; the first generated bit ends up in the MSB.
    always_comb begin
        w_prbs_adv  = w_prbs_cur;
        w_prbs_word = '0;
        for (int i = 0; i < D; i++) begin
            w_prbs_word = {w_prbs_word[D-2:0], w_prbs_adv[8] ^ w_prbs_adv[4]};
            w_prbs_adv  = {w_prbs_adv[7:0], w_prbs_adv[8] ^ w_prbs_adv[4]};
        end
    end
`endif

    // r_word and r_frame are shift registers. The bit pair for the current phase always sits at the top of each lane.
    always_comb begin
        w_state_nx = r_state;
        w_k_nx     = r_k;
        w_cnt_nx   = r_cnt;
        w_stop_nx  = r_stop;
        w_ramp_nx  = r_ramp;
        w_uflow_nx = r_underflow;
        w_word_nx  = r_word;
        w_frame_nx = r_frame;
`ifdef ADC_TX_PRBS_EN
        w_prbs_nx  = r_prbs;
`endif
        if (r_state == IDLE) begin
            w_k_nx    = '0;
            w_cnt_nx  = '0;
            w_stop_nx = 1'b0;
            if (bus.enable) begin
                w_state_nx = SYNC;
                w_word_nx  = TRAIN;
                w_frame_nx = FRAME;
            end
        end else begin
            w_stop_nx  = r_stop | ~bus.enable;
            w_word_nx  = {r_word[D-1:S] << 2, r_word[S-1:0] << 2};
            w_frame_nx = r_frame << 2;
            w_k_nx     = (r_k == K_LAST) ? '0 : r_k + 1'b1;
            if (r_k == K_LAST) begin
                w_frame_nx = FRAME;
                if (w_stop_nx) begin
                    w_state_nx = IDLE;
                end else if (r_state == SYNC && r_cnt != CNT_LAST) begin
                    w_cnt_nx  = r_cnt + 1'b1;
                    w_word_nx = TRAIN;
                end else begin
                    w_state_nx = RUN;
                    w_ramp_nx  = w_ramp_cur;
`ifdef ADC_TX_PRBS_EN
                    w_prbs_nx  = w_prbs_cur;
`endif
                    case (bus.mode)
                        2'd0: begin
                            if (r_sample_ready && bus.sample_valid) begin
                                w_word_nx = bus.sample_in;
                            end else begin
                                w_word_nx  = '0;
                                w_uflow_nx = 1'b1;
                            end
                        end
                        2'd2: begin
                            w_word_nx = w_ramp_cur;
                            w_ramp_nx = w_ramp_cur + 1'b1;
                        end
`ifdef ADC_TX_PRBS_EN
                        2'd3: begin
                            w_word_nx = w_prbs_word;
                            w_prbs_nx = w_prbs_adv;
                        end
`endif
                        default: w_word_nx = bus.pattern;
                    endcase
                end
            end
        end
        w_ready_nx = (w_state_nx == RUN) && (w_k_nx == K_LAST) &&
                     (bus.mode == 2'd0) && !w_stop_nx;
    end

    always_ff @(posedge i_ref_clk or negedge i_ref_rst_n) begin
        if (!i_ref_rst_n) begin
            r_state        <= IDLE;
            r_k            <= '0;
            r_cnt          <= '0;
            r_stop         <= 1'b0;
            r_word         <= '0;
            r_frame        <= '0;
            r_ramp         <= '0;
            r_underflow    <= 1'b0;
            r_lane_rise    <= '0;
            r_lane_fall    <= '0;
            r_frame_rise   <= 1'b0;
            r_frame_fall   <= 1'b0;
            r_word_start   <= 1'b0;
            r_in_sync      <= 1'b0;
            r_sample_ready <= 1'b0;
`ifdef ADC_TX_PRBS_EN
            r_prbs         <= 9'h1FF;
`endif
        end else begin
            r_state        <= w_state_nx;
            r_k            <= w_k_nx;
            r_cnt          <= w_cnt_nx;
            r_stop         <= w_stop_nx;
            r_word         <= w_word_nx;
            r_frame        <= w_frame_nx;
            r_ramp         <= w_ramp_nx;
            r_underflow    <= w_uflow_nx;
            r_in_sync      <= (w_state_nx == RUN);
            r_sample_ready <= w_ready_nx;
`ifdef ADC_TX_PRBS_EN
            r_prbs         <= w_prbs_nx;
`endif
            if (w_state_nx == IDLE) begin
                r_lane_rise  <= '0;
                r_lane_fall  <= '0;
                r_frame_rise <= 1'b0;
                r_frame_fall <= 1'b0;
                r_word_start <= 1'b0;
            end else begin
                r_lane_rise  <= {w_word_nx[D-1], w_word_nx[S-1]};
                r_lane_fall  <= {w_word_nx[D-2], w_word_nx[S-2]};
                r_frame_rise <= w_frame_nx[S-1];
                r_frame_fall <= w_frame_nx[S-2];
                r_word_start <= (w_k_nx == '0);
            end
        end
    end

    assign bus.lane_rise    = r_lane_rise;
    assign bus.lane_fall    = r_lane_fall;
    assign bus.frame_rise   = r_frame_rise;
    assign bus.frame_fall   = r_frame_fall;
    assign bus.word_start   = r_word_start;
    assign bus.in_sync      = r_in_sync;
    assign bus.sample_ready = r_sample_ready;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_adc_lvds_tx_emulator.sv
// Directed bench for adc_lvds_tx_emulator: the full-size instance plus a D=4/S=2 instance for ramp wrap.
// The small instance reaches the ramp wraparound in a few cycles.
module tb_adc_lvds_tx_emulator;
    logic clk;
    logic rst_n;
    int   nChecks;
    int   nErrors;

    adc_lvds_tx_emulator_if #(.D(16)) bus ();
    adc_lvds_tx_emulator_if #(.D(4))  bus2 ();

    adc_lvds_tx_emulator #(.D(16), .S(8), .SYNC_WORDS(16)) dut (
        .i_ref_clk   (clk),
        .i_ref_rst_n (rst_n),
        .bus         (bus.slave)
    );

    adc_lvds_tx_emulator #(.D(4), .S(2), .SYNC_WORDS(2)) dutSmall (
        .i_ref_clk   (clk),
        .i_ref_rst_n (rst_n),
        .bus         (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef ADC_TX_PRBS_EN
    function automatic logic [15:0] prbsWord(input logic [8:0] seed);
        logic [8:0]  s;
        logic [15:0] w;
        s = seed;
        w = '0;
        for (int i = 0; i < 16; i++) begin
            w = {w[14:0], s[8] ^ s[4]};
            s = {s[7:0], s[8] ^ s[4]};
        end
        return w;
    endfunction
    localparam logic [15:0] MODE3_EXP = prbsWord(9'h1FF);
`else
    localparam logic [15:0] MODE3_EXP = 16'h1234;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nChecks++;
        assert (obs === expv) else begin
            nErrors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] nMode, input logic nEn, input logic nValid);
        bus.mode         = nMode;
        bus.enable       = nEn;
        bus.sample_valid = nValid;
    endtask

    // Capture one word starting at its k=0 cycle. Optionally apply new controls after the sample at actPhase.
    task automatic runWord(input string tag, input logic [15:0] expWord, input logic [3:0] expRdy,
                           input int actPhase, input logic [1:0] nMode, input logic nEn,
                           input logic nValid);
        logic [7:0] b1, b0, fr;
        logic [3:0] ws, rdy, sy;
        b1 = '0; b0 = '0; fr = '0; ws = '0; rdy = '0; sy = '0;
        for (int p = 0; p < 4; p++) begin
            @(negedge clk);
            b1  = {b1[5:0], bus.lane_rise[1], bus.lane_fall[1]};
            b0  = {b0[5:0], bus.lane_rise[0], bus.lane_fall[0]};
            fr  = {fr[5:0], bus.frame_rise, bus.frame_fall};
            ws  = {bus.word_start, ws[3:1]};
            rdy = {bus.sample_ready, rdy[3:1]};
            sy  = {bus.in_sync, sy[3:1]};
            if (p == actPhase) applyStimulus(nMode, nEn, nValid);
        end
        checkOutput({tag, ".word"},  32'({b1, b0}), 32'(expWord));
        checkOutput({tag, ".frame"}, 32'(fr), 32'h0000_00F0);
        checkOutput({tag, ".wstart"}, 32'(ws), 32'h0000_0001);
        checkOutput({tag, ".ready"}, 32'(rdy), 32'(expRdy));
        checkOutput({tag, ".insync"}, 32'(sy), 32'h0000_000F);
    endtask

    function automatic logic [9:0] mainOutputs();
        return {bus.lane_rise, bus.lane_fall, bus.frame_rise, bus.frame_fall,
                bus.word_start, bus.in_sync, bus.sample_ready, bus.underflow};
    endfunction

    initial begin
        logic found;
        int   k;
        nChecks = 0;
        nErrors = 0;
        rst_n = 1'b0;
        bus.enable = 1'b0;  bus.mode = 2'd0;  bus.pattern = '0;
        bus.sample_in = '0; bus.sample_valid = 1'b0;
        bus2.enable = 1'b0; bus2.mode = 2'd0; bus2.pattern = '0;
        bus2.sample_in = '0; bus2.sample_valid = 1'b0;

        @(negedge clk);
        checkOutput("reset.main", 32'(mainOutputs()), 32'd0);
        checkOutput("reset.small", 32'({bus2.lane_rise, bus2.lane_fall, bus2.frame_rise,
                    bus2.frame_fall, bus2.word_start, bus2.in_sync, bus2.underflow}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle.main", 32'(mainOutputs()), 32'd0);

        $display("[TB] small instance ramp wrap");
        bus2.mode = 2'd2;
        bus2.enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = bus2.in_sync;
        end
        checkOutput("small.sync_reached", 32'(found), 32'd1);
        for (int n = 0; n < 18; n++) begin
            checkOutput($sformatf("small.ramp%0d", n),
                        32'({bus2.lane_rise[1], bus2.lane_fall[1], bus2.lane_rise[0], bus2.lane_fall[0]}),
                        32'(n % 16));
            @(negedge clk);
        end
        bus2.enable = 1'b0;

        $display("[TB] main instance SYNC training");
        bus.pattern = 16'h1234;
        bus.mode    = 2'd1;
        bus.enable  = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            k = i % 4;
            checkOutput($sformatf("sync.c%0d", i + 1),
                        32'({bus.lane_rise, bus.lane_fall, bus.frame_rise, bus.frame_fall,
                             bus.word_start, bus.in_sync, bus.sample_ready}),
                        32'({2'b11, 2'b00, k < 2, k < 2, k == 0, 1'b0, 1'b0}));
        end

        $display("[TB] main instance RUN words");
        runWord("pat",    16'h1234, 4'b0000, 1, 2'd2, 1'b1, 1'b0);
        bus.sample_in = 16'hA5C3;
        runWord("ramp0",  16'h0000, 4'b0000, -1, 2'd2, 1'b1, 1'b0);
        runWord("ramp1",  16'h0001, 4'b1000, 1, 2'd0, 1'b1, 1'b1);
        runWord("data0",  16'hA5C3, 4'b1000, -1, 2'd0, 1'b1, 1'b1);
        checkOutput("data0.underflow", 32'(bus.underflow), 32'd0);
        runWord("data1",  16'hA5C3, 4'b1000, 2, 2'd0, 1'b1, 1'b0);
        runWord("starve", 16'h0000, 4'b1000, 0, 2'd0, 1'b1, 1'b1);
        checkOutput("starve.underflow", 32'(bus.underflow), 32'd1);
        runWord("data2",  16'hA5C3, 4'b0000, 1, 2'd3, 1'b1, 1'b1);
        checkOutput("data2.underflow", 32'(bus.underflow), 32'd1);
        runWord("mode3",  MODE3_EXP, 4'b0000, 1, 2'd3, 1'b0, 1'b1);

        bus.enable = 1'b1;
        @(negedge clk);
        checkOutput("stop.idle", 32'(mainOutputs()), 32'd1);
        @(negedge clk);
        checkOutput("restart.sync_k0", 32'(mainOutputs()), 32'({2'b11, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}));

        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            found = bus.in_sync;
        end
        checkOutput("restart.sync_reached", 32'(found), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        checkOutput("k2.insync_before_reset", 32'(bus.in_sync), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 32'(mainOutputs()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule

// File: doc/adc_lvds_tx_emulator.md
Name: adc_lvds_tx_emulator

Overview:
- Bit-rate transmitter that emulates the ADC's two-lane LVDS output: data lanes plus frame.
- Drives ODDR-ready rise/fall bit pairs for both data lanes and the frame lane.
- Serves as a loopback/bench source for the capture path and as a board-level test-pattern generator.
- Each D-bit sample is split across two lanes, S bits per lane, MSB first, DDR.

Parameters:
- D, 16, sample width; must equal 2*S.
- S, 8, bits per lane per word; must be even. One word spans S/2 clock cycles.
- SYNC_WORDS, 16, number of training words sent after enable before RUN.

Ports:
- ref_clk  input  1  bit clock; one rise/fall bit pair per lane per cycle.
- ref_rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  start/stop transmission; level-sensitive.
- mode  input  2  0=data, 1=fixed pattern, 2=ramp, 3=PRBS9 (see optional feature).
- pattern  input  D  fixed word for mode 1.
- sample_in  input  D  user sample for mode 0.
- sample_valid  input  1  sample_in valid.
- sample_ready  output  1  block accepts sample_in this cycle.
- lane_rise  output  2  rising-edge bit per lane; lane1 carries D[D-1:S], lane0 carries D[S-1:0].
- lane_fall  output  2  falling-edge bit per lane.
- frame_rise  output  1  frame bit, rising edge.
- frame_fall  output  1  frame bit, falling edge.
- word_start  output  1  high on phase-0 cycle of every transmitted word.
- in_sync  output  1  high while in RUN.
- underflow  output  1  sticky; set on a mode-0 data starvation, cleared only by reset.

Behaviour:
- Reset values: all outputs 0. State IDLE, phase counter 0, ramp 0, PRBS state 9'h1FF.
- Phase counter k counts 0..S/2-1 in SYNC/RUN and wraps. It is held at 0 in IDLE.
- Serialization, cycle k of a word, per lane byte b:
  - lane_rise = b[S-1-2k], lane_fall = b[S-2-2k].
  - Frame pattern is S bits, upper half 1s, lower half 0s (8'hF0 for S=8). frame_rise/frame_fall follow the same bit indexing.
- All outputs are registered.
- The word register loads at the end of cycle k=S/2-1. Its bits appear from the next cycle (k=0), where word_start=1.
- IDLE:
  - Lanes and frame are 0.
  - enable=1 -> SYNC, with k=0 next cycle.
- SYNC:
  - Transmits training word {S/2{2'b10}} on both lanes (16'hAAAA for S=8), with normal frame.
  - Ends after SYNC_WORDS complete words -> RUN; in_sync rises with the first RUN word_start.
- RUN:
  - Word source is selected by mode, sampled at the k=S/2-1 load cycle. A mode change therefore takes effect only at a word boundary.
  - mode 0: sample_ready=1 only at k=S/2-1. ready&valid loads sample_in. If valid=0 at that cycle, load 0 and set underflow.
  - mode 1: load pattern.
  - mode 2: load ramp, then ramp <= ramp+1, modulo 2^D (0xFFFF -> 0x0000). Ramp resets to 0 on each SYNC->RUN transition.
  - mode 3: see optional feature.
- sample_ready is 0 outside RUN and in modes 1-3.
- enable deassert in SYNC or RUN: finish the current word through k=S/2-1, then IDLE; outputs are 0 from the next cycle.
- enable re-asserted during that final word: no effect; IDLE, then SYNC again.
- Async reset mid-word: outputs go to 0 immediately; no partial-word completion.

Optional Feature:
- Macro ADC_TX_PRBS_EN.
- Defined: mode 3 loads D bits of PRBS9 (x^9+x^5+1), advancing D steps per word, MSB = first generated bit. The PRBS state reseeds to 9'h1FF on each SYNC->RUN transition.
- Undefined: no PRBS logic is built; mode 3 behaves exactly as mode 1.

Test Plan:
- Reset, then enable=1 with SYNC_WORDS=16 -> 64 cycles of lane pattern 1,0 per rise/fall with frame 1,1,1,1,0,0,0,0 per word; in_sync=1 at cycle 65 with word_start.
- Mode 0, sample_in=16'hA5C3 held valid -> lane1 rise/fall pairs (1,0)(1,0)(0,1)(0,1); lane0 pairs (1,1)(0,0)(0,0)(1,1); one ready pulse per 4 cycles.
- Mode 0, valid dropped for one load slot -> that word is all-zero; underflow=1 and stays 1 after valid returns.
- Mode 2 with ramp forced near 0xFFFE (run 65534 words) -> words 0xFFFE, 0xFFFF, 0x0000 in order.
- Mode switch 1->2 mid-word (pattern=16'h1234) -> current word completes as 0x1234; the next word is the ramp value.
- enable=0 at k=1 -> bits continue through k=3, then lanes/frame/in_sync=0. Async reset at k=2 -> all outputs 0 the same cycle.
